// File: rtl/clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_monitor
// Description : Receive-side checker for synchronous mod-N clock dividers.
//               Measures the period and high-phase length of every divided
//               clock cycle in clk cycles, compares them against the expected
//               ratio/duty, tracks lock, and flags a stalled divider.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk_in,
  input  logic [CNT_W-1:0] exp_n,
  input  logic [CNT_W-1:0] exp_high,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             stuck
);

  // Match counter only needs to reach LOCK_CNT, then saturates there.
  localparam int MC_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [MC_W-1:0]  C_LOCK    = MC_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    SEEK = 1'b0,
    MEAS = 1'b1
  } state_t;

  state_t           state_q;
  logic             d1_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hi_cap_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic [MC_W-1:0]  match_cnt_q;
  logic             meas_valid_q;
  logic             locked_q;
  logic             err_q;
  logic             stuck_q;

  logic             rise_w;
  logic             fall_w;
  logic             match_w;
  logic [MC_W-1:0]  match_cnt_d;

  // Edge detection against the previous sample, and the period comparison.
  // A period can only close on a rise, and a fall always precedes it, so
  // hi_cap_q holds the current period's high length at compare time.
  always_comb begin
    rise_w      = div_clk_in & ~d1_q;
    fall_w      = ~div_clk_in & d1_q;
    match_w     = (cnt_q == exp_n) && (hi_cap_q == exp_high);
    match_cnt_d = (match_cnt_q == C_LOCK) ? C_LOCK : (match_cnt_q + MC_W'(1));
  end

  // Measurement FSM: SEEK waits for the first rise, MEAS counts full periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEEK;
      d1_q         <= 1'b0;
      cnt_q        <= '0;
      hi_cap_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      match_cnt_q  <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      d1_q         <= div_clk_in;
      meas_valid_q <= 1'b0;
      err_q        <= 1'b0;
      stuck_q      <= 1'b0;

      if (state_q == SEEK) begin
        // The first rise only opens a period; nothing is reported yet.
        if (rise_w) begin
          state_q <= MEAS;
          cnt_q   <= C_CNT_ONE;
        end
      end else begin
        cnt_q <= cnt_q + C_CNT_ONE;
        if (fall_w) begin
          hi_cap_q <= cnt_q;
        end

        if (rise_w) begin
          period_q     <= cnt_q;
          high_time_q  <= hi_cap_q;
          meas_valid_q <= 1'b1;
          cnt_q        <= C_CNT_ONE;
          if (match_w) begin
            match_cnt_q <= match_cnt_d;
            if (match_cnt_d == C_LOCK) begin
              locked_q <= 1'b1;
            end
          end else begin
            match_cnt_q <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b1;
          end
        end else if (cnt_q == C_CNT_MAX) begin
          // Counter would overflow: the divider has stalled. Go re-acquire,
          // keeping the last good measurement on the outputs.
          stuck_q     <= 1'b1;
          locked_q    <= 1'b0;
          match_cnt_q <= '0;
          state_q     <= SEEK;
        end
      end
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign stuck      = stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_monitor
// Description : Scoreboard testbench for clk_div_monitor. Two instances
//               (LOCK_CNT 4 and 1) watch the same divided clock; a reference
//               model based on rise/fall timestamps predicts every report.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_clk_div_monitor;

  localparam int STUCK_LIM = 255;

  typedef struct {
    int cyc;
    bit mv;
    bit er;
    bit st;
    int per;
    int hi;
    bit lk;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic [7:0] exp_n = 8'd0;
  logic [7:0] exp_high = 8'd0;

  logic [7:0] per_o [2];
  logic [7:0] hi_o  [2];
  logic       mv_o  [2];
  logic       lk_o  [2];
  logic       er_o  [2];
  logic       st_o  [2];

  always #5 clk = ~clk;

  clk_div_monitor #(.CNT_W(8), .LOCK_CNT(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .div_clk_in(din), .exp_n(exp_n), .exp_high(exp_high),
    .period(per_o[0]), .high_time(hi_o[0]), .meas_valid(mv_o[0]),
    .locked(lk_o[0]), .err(er_o[0]), .stuck(st_o[0])
  );

  clk_div_monitor #(.CNT_W(8), .LOCK_CNT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .div_clk_in(din), .exp_n(exp_n), .exp_high(exp_high),
    .period(per_o[1]), .high_time(hi_o[1]), .meas_valid(mv_o[1]),
    .locked(lk_o[1]), .err(er_o[1]), .stuck(st_o[1])
  );

  int   lock_req [2] = '{4, 1};
  rec_t q [2][$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  // Reference model state: timestamps of edges, not counters.
  bit prev_in = 1'b0;
  bit measuring = 1'b0;
  int last_rise = 0;
  int last_fall = 0;
  int last_p = 0;
  int last_h = 0;
  int streak [2] = '{0, 0};
  bit mlock  [2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_all(input int s, input bit mv, input bit er, input bit st);
    rec_t r;
    for (int i = 0; i < 2; i++) begin
      r.cyc = s; r.mv = mv; r.er = er; r.st = st;
      r.per = last_p; r.hi = last_h; r.lk = mlock[i];
      q[i].push_back(r);
    end
  endtask

  // Predict the DUT reaction to sample index s (input v, reset r).
  task automatic model(input int s, input bit v, input bit r);
    bit rise, fall, good;
    if (r) begin
      prev_in = 1'b0; measuring = 1'b0; last_p = 0; last_h = 0;
      for (int i = 0; i < 2; i++) begin streak[i] = 0; mlock[i] = 1'b0; end
      push_all(s, 1'b0, 1'b0, 1'b0);
      return;
    end
    rise = v && !prev_in;
    fall = !v && prev_in;
    if (!measuring) begin
      if (rise) begin measuring = 1'b1; last_rise = s; end
    end else if (rise) begin
      last_p = s - last_rise;
      last_h = last_fall - last_rise;
      good = (last_p == int'(exp_n)) && (last_h == int'(exp_high));
      for (int i = 0; i < 2; i++) begin
        if (good) begin
          streak[i] = (streak[i] + 1 > lock_req[i]) ? lock_req[i] : streak[i] + 1;
          if (streak[i] == lock_req[i]) mlock[i] = 1'b1;
        end else begin
          streak[i] = 0; mlock[i] = 1'b0;
        end
      end
      push_all(s, 1'b1, !good, 1'b0);
      last_rise = s;
    end else begin
      if (fall) last_fall = s;
      if (s - last_rise == STUCK_LIM) begin
        measuring = 1'b0;
        for (int i = 0; i < 2; i++) begin streak[i] = 0; mlock[i] = 1'b0; end
        push_all(s, 1'b0, 1'b0, 1'b1);
      end
    end
    prev_in = v;
  endtask

  // Called at a negedge: drive the next sample and predict its outcome.
  task automatic step(input bit v, input bit r);
    din = v;
    rst = r;
    model(cyc + 1, v, r);
    @(negedge clk);
  endtask

  task automatic run_div(input int n, input int h, input int periods,
                         input int en, input int eh);
    exp_n    = 8'(en);
    exp_high = 8'(eh);
    for (int p = 0; p < periods; p++)
      for (int k = 0; k < n; k++)
        step(k < h, 1'b0);
  endtask

  task automatic check_inst(input int i);
    rec_t r;
    while (q[i].size() > 0 && q[i][0].cyc < cyc) begin
      r = q[i].pop_front();
      tests++; fails++;
      $display("FAIL missed_event inst%0d cyc%0d: no output seen, required mv=%0d err=%0d stuck=%0d",
               i, r.cyc, r.mv, r.er, r.st);
    end
    if (q[i].size() > 0 && q[i][0].cyc == cyc) begin
      r = q[i].pop_front();
      tests++;
      if (mv_o[i] !== r.mv || er_o[i] !== r.er || st_o[i] !== r.st ||
          int'(per_o[i]) != r.per || int'(hi_o[i]) != r.hi || lk_o[i] !== r.lk) begin
        fails++;
        $display("FAIL event inst%0d cyc%0d: got mv=%0d err=%0d stuck=%0d per=%0d hi=%0d lk=%0d, required mv=%0d err=%0d stuck=%0d per=%0d hi=%0d lk=%0d",
                 i, cyc, mv_o[i], er_o[i], st_o[i], per_o[i], hi_o[i], lk_o[i],
                 r.mv, r.er, r.st, r.per, r.hi, r.lk);
      end
    end else if (mv_o[i] || er_o[i] || st_o[i]) begin
      tests++; fails++;
      $display("FAIL spurious inst%0d cyc%0d: got mv=%0d err=%0d stuck=%0d, required all 0",
               i, cyc, mv_o[i], er_o[i], st_o[i]);
    end
  endtask

  // Monitor: checks DUT outputs shortly after every active edge.
  always begin
    @(posedge clk);
    #2;
    if (mon_en) begin
      check_inst(0);
      check_inst(1);
    end
  end

  initial begin
    int n, h, per, en, eh;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    repeat (3) step(1'b0, 1'b1);

    // N=3 duty 1/3, then N=4 duty 1/2 matching and mismatching.
    run_div(3, 1, 8, 3, 1);
    run_div(4, 2, 6, 4, 2);
    run_div(4, 2, 4, 4, 1);

    // Lock on N=3, change to N=5, relock with new expectation.
    run_div(3, 1, 6, 3, 1);
    run_div(5, 2, 2, 3, 1);
    run_div(5, 2, 6, 5, 2);

    // Stalled divider while locked, then resume.
    run_div(3, 1, 6, 3, 1);
    repeat (300) step(1'b0, 1'b0);
    run_div(3, 1, 6, 3, 1);

    // Reset mid-period while locked, then rebuild lock.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    run_div(3, 1, 7, 3, 1);

    // Minimum ratio N=2.
    run_div(2, 1, 6, 2, 1);

    // Divider held in reset after our reset: constant low stays silent.
    step(1'b0, 1'b1);
    repeat (300) step(1'b0, 1'b0);

    // Randomized segments with occasional resets.
    for (int seg = 0; seg < 30; seg++) begin
      n   = $urandom_range(2, 12);
      h   = $urandom_range(1, n - 1);
      per = $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 1) begin en = n; eh = h; end
      else begin en = $urandom_range(0, 13); eh = $urandom_range(0, 13); end
      run_div(n, h, per, en, eh);
      if ($urandom_range(0, 7) == 0) step(1'($urandom_range(0, 1)), 1'b1);
    end

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    @(posedge clk);
    #3;
    for (int i = 0; i < 2; i++) begin
      while (q[i].size() > 0) begin
        rec_t r;
        r = q[i].pop_front();
        tests++; fails++;
        $display("FAIL unconsumed inst%0d cyc%0d: event never observed, required mv=%0d stuck=%0d",
                 i, r.cyc, r.mv, r.st);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
